fpu_issue_seq: RTL
==================

// Module: fpu_issue_seq
// PURPOSE
//  Initiator for the FPU_Top operand/opcode interface. Accepts one encoded FP request per valid/ready handshake and
//  drives operands, frm and a one-hot sfpu_op for exactly one cycle. Collects the registered result, flags and the
//  exception indication, then returns them on a valid/ready response channel. Keeps the sticky fflags CSR value.
// PARAMETERS
//  STD   15  operand MSB index (FP width = STD+1), must match FPU_Top std
// PORTS
//  clk          in   1      clock; all state updates on posedge
//  rst          in   1      asynchronous, active-high reset
//  req_valid    in   1      request valid
//  req_ready    out  1      request accepted when req_valid & req_ready
//  req_op       in   5      sfpu_op bit index 0..21; 22..31 illegal
//  req_sgn      in   1      for ops 14/15 only: 1 -> set sfpu_op[23] (signed), 0 -> sfpu_op[22] (unsigned)
//  req_frm      in   3      rounding mode
//  req_a/b/c    in   STD+1  FP operands A, B, C
//  req_int      in   32     integer operand (FCVT.P.W)
//  rsp_valid    out  1      response valid; held until rsp_ready
//  rsp_ready    in   1      response consumed when rsp_valid & rsp_ready
//  rsp_fp       out  STD+1  FP result (FPU_resultant)
//  rsp_int      out  32     integer result (FPU_Result_rd)
//  rsp_flags    out  5      {NV,DZ,OF,UF,NX} for this op
//  rsp_exc      out  1      input-validation exception occurred (or illegal op)
//  fflags       out  5      sticky accumulated flags
//  fflags_clr   in   1      clear sticky flags
//  fpu_a/b/c    out  STD+1  to FPU Operand_A/B/C
//  fpu_int      out  32     to FPU Operand_Int
//  fpu_frm      out  3      to FPU frm
//  fpu_sfpu_op  out  24     to FPU sfpu_op (one-hot, plus sign modifier)
//  fpu_vfpu_op  out  28     to FPU vfpu_op; constant 0
//  fpu_sel      out  3      to FPU fpu_sel; constant 0
//  fpu_rst_l    out  1      to FPU rst_l; = ~rst
//  fpu_res      in   STD+1  from FPU_resultant
//  fpu_rd       in   32     from FPU_Result_rd
//  fpu_flags    in   5      from S_Flags
//  fpu_exc      in   1      from Exception_flag (combinational in FPU)
// BEHAVIOUR
//  - Reset: state IDLE; all outputs 0 except req_ready=0 while rst=1, =1 on first IDLE cycle; fpu_sfpu_op=0.
//  - FSM IDLE -> ISSUE -> WAIT -> RESP -> IDLE. req_ready = (state==IDLE).
//  - IDLE: on handshake register op/sgn/frm/a/b/c/int; -> ISSUE (legal) or RESP (illegal).
//  - ISSUE (1 cycle): fpu_sfpu_op = 1<<req_op, plus bit 23/22 for ops 14/15; sample fpu_exc into exc_q.
//  - WAIT (1 cycle): fpu_sfpu_op = 0; latch rsp_fp=fpu_res, rsp_int=fpu_rd, rsp_flags=fpu_flags, rsp_exc=exc_q.
//  - RESP: rsp_valid=1; rsp_* stable until rsp_ready; on handshake -> IDLE, rsp_valid=0 next cycle.
//  - Latency: accept at edge T -> rsp_valid high from cycle T+3; throughput 1 op per 4 cycles minimum.
//  - fpu_a/b/c/int/frm hold the last accepted request values outside ISSUE (0 after reset).
//  - Illegal op: no FPU issue; rsp_fp=0, rsp_int=0, rsp_flags=5'b10000, rsp_exc=1.
//  - fflags: |= rsp_flags on the cycle rsp_* is loaded. fflags_clr alone -> 0. clr on load cycle -> fflags = new
//    flags only.
//  - rst asserted mid-operation (any state): immediate return to IDLE, op dropped, no response produced.
// TESTING (bf16: 1.0=3F80, 2.0=4000, 3.0=4040)
//  - op0 FADD a=3F80 b=4000 -> rsp_valid at T+3, rsp_fp=4040, rsp_flags=0, rsp_exc=0; sfpu_op=1 exactly 1 cycle.
//  - op3 FDIV a=3F80 b=0000 -> rsp_exc=1, rsp_flags[3]=1; fflags[3]=1 persists until fflags_clr.
//  - op14 sgn=1 a=4040 -> fpu_sfpu_op=24'h804000 in ISSUE; rsp_int=32'd3, rsp_flags=0.
//  - rsp_ready=0 for 5 cycles -> rsp_* constant, req_ready=0; rsp_ready=1 -> IDLE, next request accepted.
//  - req_op=25 -> no FPU op driven, rsp_flags=10000, rsp_exc=1 at T+1 (RESP); fflags[4]=1.
//  - rst pulse during ISSUE -> fpu_sfpu_op=0 same cycle, no rsp_valid; clean FADD afterwards passes.

Source files
------------

// File: rtl/fpu_issue_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : fpu_issue_seq                                                     |
// | Issues one FP request to FPU_Top and returns its result and flags.         |
// | Rev    : 1.0                                                               |
// +----------------------------------------------------------------------------+
module fpu_issue_seq #(
  parameter int STD = 15
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           req_valid,
  output logic           req_ready,
  input  logic [4:0]     req_op,
  input  logic           req_sgn,
  input  logic [2:0]     req_frm,
  input  logic [STD:0]   req_a,
  input  logic [STD:0]   req_b,
  input  logic [STD:0]   req_c,
  input  logic [31:0]    req_int,
  output logic           rsp_valid,
  input  logic           rsp_ready,
  output logic [STD:0]   rsp_fp,
  output logic [31:0]    rsp_int,
  output logic [4:0]     rsp_flags,
  output logic           rsp_exc,
  output logic [4:0]     fflags,
  input  logic           fflags_clr,
  output logic [STD:0]   fpu_a,
  output logic [STD:0]   fpu_b,
  output logic [STD:0]   fpu_c,
  output logic [31:0]    fpu_int,
  output logic [2:0]     fpu_frm,
  output logic [23:0]    fpu_sfpu_op,
  output logic [27:0]    fpu_vfpu_op,
  output logic [2:0]     fpu_sel,
  output logic           fpu_rst_l,
  input  logic [STD:0]   fpu_res,
  input  logic [31:0]    fpu_rd,
  input  logic [4:0]     fpu_flags,
  input  logic           fpu_exc
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  localparam logic [4:0] c_last_op       = 5'd21;
  localparam logic [4:0] c_illegal_flags = 5'b10000;

  state_t       r_state, w_state_nxt;
  logic [4:0]   r_op;
  logic         r_sgn;
  logic [2:0]   r_frm;
  logic [STD:0] r_a, r_b, r_c;
  logic [31:0]  r_int;
  logic         r_exc_q;
  logic [STD:0] r_rsp_fp;
  logic [31:0]  r_rsp_int;
  logic [4:0]   r_rsp_flags;
  logic         r_rsp_exc;
  logic [4:0]   r_fflags;

  logic         w_fire, w_legal, w_load;
  logic [4:0]   w_new_flags;
  logic [23:0]  w_sfpu_op;

  assign w_fire      = req_valid & req_ready;
  assign w_legal     = (req_op <= c_last_op);
  // Results are captured either from the FPU (end of WAIT) or synthesised at accept time for illegal ops
  assign w_load      = (r_state == S_WAIT) | (w_fire & ~w_legal);
  assign w_new_flags = (r_state == S_WAIT) ? fpu_flags : c_illegal_flags;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_fire) w_state_nxt = w_legal ? S_ISSUE : S_RESP;
      S_ISSUE: w_state_nxt = S_WAIT;
      S_WAIT:  w_state_nxt = S_RESP;
      S_RESP:  if (rsp_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_sfpu_op = '0;
    if (r_state == S_ISSUE) begin
      w_sfpu_op = 24'd1 << r_op;
      // Integer conversions carry a signedness modifier in the top two bits
      if (r_op == 5'd14 || r_op == 5'd15) begin
        if (r_sgn) w_sfpu_op[23] = 1'b1;
        else       w_sfpu_op[22] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_op        <= '0;
      r_sgn       <= 1'b0;
      r_frm       <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_c         <= '0;
      r_int       <= '0;
      r_exc_q     <= 1'b0;
      r_rsp_fp    <= '0;
      r_rsp_int   <= '0;
      r_rsp_flags <= '0;
      r_rsp_exc   <= 1'b0;
      r_fflags    <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_fire) begin
        r_op  <= req_op;
        r_sgn <= req_sgn;
        r_frm <= req_frm;
        r_a   <= req_a;
        r_b   <= req_b;
        r_c   <= req_c;
        r_int <= req_int;
      end
      if (r_state == S_ISSUE) r_exc_q <= fpu_exc;
      if (r_state == S_WAIT) begin
        r_rsp_fp    <= fpu_res;
        r_rsp_int   <= fpu_rd;
        r_rsp_flags <= fpu_flags;
        r_rsp_exc   <= r_exc_q;
      end else if (w_fire & ~w_legal) begin
        r_rsp_fp    <= '0;
        r_rsp_int   <= '0;
        r_rsp_flags <= c_illegal_flags;
        r_rsp_exc   <= 1'b1;
      end
      // A clear coinciding with a load keeps only the newly reported flags
      if (w_load)          r_fflags <= fflags_clr ? w_new_flags : (r_fflags | w_new_flags);
      else if (fflags_clr) r_fflags <= '0;
    end
  end

  assign req_ready   = (r_state == S_IDLE) & ~rst;
  assign rsp_valid   = (r_state == S_RESP);
  assign rsp_fp      = r_rsp_fp;
  assign rsp_int     = r_rsp_int;
  assign rsp_flags   = r_rsp_flags;
  assign rsp_exc     = r_rsp_exc;
  assign fflags      = r_fflags;
  assign fpu_a       = r_a;
  assign fpu_b       = r_b;
  assign fpu_c       = r_c;
  assign fpu_int     = r_int;
  assign fpu_frm     = r_frm;
  assign fpu_sfpu_op = w_sfpu_op;
  assign fpu_vfpu_op = '0;
  assign fpu_sel     = '0;
  assign fpu_rst_l   = ~rst;

endmodule
`default_nettype wire
